cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter IW, default 16: instruction width; opcode = instr[IW-1:IW-3], op = instr[IW-4:IW-5]; IW below 16 SHALL be rejected at elaboration.
REQ-002 Parameter MEM_WAIT, default 1: RAM read wait cycles, legal 0..15.
REQ-003 Ports SHALL be, in this order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- run  in  1  advance enable; 0 = stall
- instr  in  IW  instruction-register contents
- nsel  out  2  register select: Rn=00, Rd=01, Rm=10
- vsel  out  2  writeback source: MDATA=00, SXIMM8=01, PC=10, C=11
- loada, loadb, loadc, loads, write  out  1 each  datapath enables
- asel, bsel  out  1 each  ALU operand selects: asel=1 gives zero A; bsel=1 gives sximm5
- loadpc, loadir, load_addr, msel, mwrite  out  1 each  fetch/memory controls; msel=1 drives RAM from the address register
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse on an undefined instruction

Function
REQ-004 Outputs SHALL be a Moore decode of the registered state and instr only; each signal not listed for a state SHALL be 0 in that state.
REQ-005 Fetch sequence:
- FETCH_PC (loadpc)
- FETCH_WAIT for MEM_WAIT cycles (msel=0); skipped when MEM_WAIT=0
- FETCH_IR (loadir)
- DECODE (no outputs)
REQ-006 Decode by {opcode,op}:
- 110,10 MOV imm: WR_IMM(nsel=Rn, vsel=SXIMM8, write)
- 110,00 MOV shift: GET_B(nsel=Rm, loadb), EXEC(asel=1, loadc), WR_C(nsel=Rd, vsel=C, write)
- 101,00 ADD and 101,10 AND: GET_A(nsel=Rn, loada), GET_B, EXEC(loadc), WR_C
- 101,01 CMP: GET_A, GET_B, CMP_EX(loads; loadc=0); no writeback
- 101,11 MVN: GET_B, EXEC(asel=1, loadc), WR_C
- 011,00 LDR: GET_A, ADDR(bsel=1, loadc), LATCH(load_addr), MEM_RD(msel=1) for MEM_WAIT cycles, WR_M(msel=1, nsel=Rd, vsel=MDATA, write)
- 100,00 STR: GET_A, ADDR, LATCH, GET_B(nsel=Rd, loadb), PASS(asel=1, loadc), MEM_WR(msel=1, mwrite) for exactly 1 cycle
- 111,xx HALT: go to HALT
REQ-007 GET_B in every sequence other than STR SHALL use nsel=Rm.
REQ-008 The last execution state of every instruction SHALL transition to FETCH_PC.
REQ-009 Any other {opcode,op} SHALL pulse illegal for 1 cycle in DECODE and go to FETCH_PC with no register or memory write.
REQ-010 HALT SHALL hold halted=1 and all other outputs 0 until reset; run has no effect in HALT.
REQ-011 When run=0, state and the wait counter SHALL hold, and all enables (load*, write, mwrite) SHALL be forced to 0; select outputs keep their state values.
REQ-012 The wait counter SHALL be 4 bits, loaded with MEM_WAIT-1 on entering a wait state, and leave that state when it reaches 0; it never wraps.
REQ-013 write and mwrite SHALL never be high in the same cycle, and each SHALL be high for exactly one advancing cycle per instruction that uses it.
REQ-014 Cycle count per instruction, with run held high, SHALL be 3 + MEM_WAIT + (number of execution states).

Reset
REQ-015 Asserting reset SHALL immediately force state to RESET_S, the counter to 0, all outputs to 0, and halted and illegal to 0, regardless of run.
REQ-016 Reset mid-instruction, including during MEM_WR, SHALL abort the instruction with no further write or mwrite.
REQ-017 The first rising clk with reset low and run high SHALL move RESET_S to FETCH_PC.

Verification
REQ-018 MEM_WAIT=1, instr=16'hD105 (MOV R1,#5): after reset release, loadpc, wait, loadir, decode, then write=1 with nsel=00, vsel=01; back in FETCH_PC at cycle 6.
REQ-019 MEM_WAIT=3, instr=16'hA0C2 (ADD): loada, loadb, loadc and write appear in order; FETCH_WAIT lasts 3 cycles; 10 cycles total.
REQ-020 instr CMP (16'hA900): loads=1 for 1 cycle and write never asserts; 7 cycles with MEM_WAIT=1.
REQ-021 STR with run pulled low during PASS for 4 cycles: all enables 0 while stalled; mwrite asserts exactly once after resume.
REQ-022 instr=16'h7800 (opcode 011, op 11): illegal pulses 1 cycle with write=mwrite=0; instr=16'hE000 then asserts halted, which holds for 20 cycles despite run toggling.
REQ-023 Reset asserted in LDR MEM_RD: outputs 0 in the same cycle; no WR_M occurs; refetch starts after release.

Source files
------------

// File: rtl/cpu_controller.sv
// Multicycle CPU control FSM: fetch, decode and per-instruction execution sequencing.
// Outputs are a Moore decode of state and instr; run=0 stalls the FSM and gates all enables.
module cpu_controller #(
    parameter int IW       = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [IW-1:0] instr,
    output logic [1:0]    nsel,
    output logic [1:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          write,
    output logic          asel,
    output logic          bsel,
    output logic          loadpc,
    output logic          loadir,
    output logic          load_addr,
    output logic          msel,
    output logic          mwrite,
    output logic          halted,
    output logic          illegal
);

    generate
        if (IW < 16) begin : g_iw_check
            $error("cpu_controller: IW must be at least 16");
        end
        if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_wait_check
            $error("cpu_controller: MEM_WAIT must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] WAIT_LOAD = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

    localparam logic [1:0] SEL_RN = 2'b00, SEL_RD = 2'b01, SEL_RM = 2'b10;
    localparam logic [1:0] V_MDATA = 2'b00, V_SXIMM8 = 2'b01, V_C = 2'b11;

    typedef enum logic [4:0] {
        RESET_S, FETCH_PC, FETCH_WAIT, FETCH_IR, DECODE,
        WR_IMM, GET_A, GET_B, EXEC, WR_C, CMP_EX,
        ADDR, LATCH, MEM_RD, WR_M, GET_BS, PASS, MEM_WR, HALT_S
    } state_t;

    typedef enum logic [3:0] {
        K_MOVI, K_MOVS, K_ALU, K_CMP, K_MVN, K_LDR, K_STR, K_HALT, K_BAD
    } kind_t;

    state_t     state, next_state;
    kind_t      kind;
    logic [3:0] cnt;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       instr_unused;

    assign opcode       = instr[IW-1:IW-3];
    assign op           = instr[IW-4:IW-5];
    assign instr_unused = ^instr[IW-6:0];

    always_comb begin
        kind = K_BAD;
        case (opcode)
            3'b110: if (op == 2'b10) kind = K_MOVI;
                    else if (op == 2'b00) kind = K_MOVS;
            3'b101: case (op)
                        2'b00, 2'b10: kind = K_ALU;
                        2'b01:        kind = K_CMP;
                        default:      kind = K_MVN;
                    endcase
            3'b011: if (op == 2'b00) kind = K_LDR;
            3'b100: if (op == 2'b00) kind = K_STR;
            3'b111: kind = K_HALT;
            default: kind = K_BAD;
        endcase
    end

    // State register and wait counter; both freeze while run is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_S;
            cnt   <= 4'd0;
        end else if (run) begin
            state <= next_state;
            if ((next_state == FETCH_WAIT || next_state == MEM_RD) && next_state != state)
                cnt <= WAIT_LOAD;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RESET_S:    next_state = FETCH_PC;
            FETCH_PC:   next_state = (MEM_WAIT == 0) ? FETCH_IR : FETCH_WAIT;
            FETCH_WAIT: next_state = (cnt == 4'd0) ? FETCH_IR : FETCH_WAIT;
            FETCH_IR:   next_state = DECODE;
            DECODE: begin
                case (kind)
                    K_MOVI:                       next_state = WR_IMM;
                    K_MOVS, K_MVN:                next_state = GET_B;
                    K_ALU, K_CMP, K_LDR, K_STR:   next_state = GET_A;
                    K_HALT:                       next_state = HALT_S;
                    default:                      next_state = FETCH_PC;
                endcase
            end
            GET_A:   next_state = (kind == K_LDR || kind == K_STR) ? ADDR : GET_B;
            GET_B:   next_state = (kind == K_CMP) ? CMP_EX : EXEC;
            EXEC:    next_state = WR_C;
            ADDR:    next_state = LATCH;
            LATCH: begin
                if (kind == K_STR)       next_state = GET_BS;
                else if (MEM_WAIT == 0)  next_state = WR_M;
                else                     next_state = MEM_RD;
            end
            MEM_RD:  next_state = (cnt == 4'd0) ? WR_M : MEM_RD;
            GET_BS:  next_state = PASS;
            PASS:    next_state = MEM_WR;
            WR_IMM, WR_C, CMP_EX, WR_M, MEM_WR: next_state = FETCH_PC;
            HALT_S:  next_state = HALT_S;
            default: next_state = RESET_S;
        endcase
    end

    // Selects follow the state directly; enables are additionally qualified by run.
    always_comb begin
        logic en_a, en_b, en_c, en_s, en_w, en_pc, en_ir, en_addr, en_mw;
        nsel      = SEL_RN;
        vsel      = V_MDATA;
        asel      = 1'b0;
        bsel      = 1'b0;
        msel      = 1'b0;
        en_a      = 1'b0;
        en_b      = 1'b0;
        en_c      = 1'b0;
        en_s      = 1'b0;
        en_w      = 1'b0;
        en_pc     = 1'b0;
        en_ir     = 1'b0;
        en_addr   = 1'b0;
        en_mw     = 1'b0;
        case (state)
            FETCH_PC: en_pc = 1'b1;
            FETCH_IR: en_ir = 1'b1;
            WR_IMM: begin
                nsel = SEL_RN;
                vsel = V_SXIMM8;
                en_w = 1'b1;
            end
            GET_A: begin
                nsel = SEL_RN;
                en_a = 1'b1;
            end
            GET_B: begin
                nsel = SEL_RM;
                en_b = 1'b1;
            end
            EXEC: begin
                asel = (kind == K_MOVS || kind == K_MVN);
                en_c = 1'b1;
            end
            WR_C: begin
                nsel = SEL_RD;
                vsel = V_C;
                en_w = 1'b1;
            end
            CMP_EX: en_s = 1'b1;
            ADDR: begin
                bsel = 1'b1;
                en_c = 1'b1;
            end
            LATCH:  en_addr = 1'b1;
            MEM_RD: msel = 1'b1;
            WR_M: begin
                msel = 1'b1;
                nsel = SEL_RD;
                vsel = V_MDATA;
                en_w = 1'b1;
            end
            GET_BS: begin
                nsel = SEL_RD;
                en_b = 1'b1;
            end
            PASS: begin
                asel = 1'b1;
                en_c = 1'b1;
            end
            MEM_WR: begin
                msel  = 1'b1;
                en_mw = 1'b1;
            end
            default: ;
        endcase
        loada     = en_a && run;
        loadb     = en_b && run;
        loadc     = en_c && run;
        loads     = en_s && run;
        write     = en_w && run;
        loadpc    = en_pc && run;
        loadir    = en_ir && run;
        load_addr = en_addr && run;
        mwrite    = en_mw && run;
        halted    = (state == HALT_S);
        illegal   = (state == DECODE) && (kind == K_BAD) && run;
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller with MEM_WAIT of 0, 1 and 3 side by side.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b1;
    logic [15:0] instr = 16'hD105;

    always #5 clk = ~clk;

    // Flag vector order: loada loadb loadc loads write asel bsel loadpc loadir load_addr msel mwrite halted illegal
    logic [1:0]  n0, v0, n1, v1, n3, v3;
    logic [13:0] f0, f1, f3;

    localparam logic [13:0] F_NONE = 14'h0000, F_LOADA = 14'h2000, F_LOADB = 14'h1000,
        F_LOADC = 14'h0800, F_LOADS = 14'h0400, F_WRITE = 14'h0200, F_ASEL = 14'h0100,
        F_BSEL = 14'h0080, F_LOADPC = 14'h0040, F_LOADIR = 14'h0020, F_LADDR = 14'h0010,
        F_MSEL = 14'h0008, F_MWRITE = 14'h0004, F_HALTED = 14'h0002, F_ILLEGAL = 14'h0001;

    cpu_controller #(.IW(16), .MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .nsel(n0), .vsel(v0),
        .loada(f0[13]), .loadb(f0[12]), .loadc(f0[11]), .loads(f0[10]), .write(f0[9]),
        .asel(f0[8]), .bsel(f0[7]), .loadpc(f0[6]), .loadir(f0[5]), .load_addr(f0[4]),
        .msel(f0[3]), .mwrite(f0[2]), .halted(f0[1]), .illegal(f0[0]));

    cpu_controller #(.IW(16), .MEM_WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .nsel(n1), .vsel(v1),
        .loada(f1[13]), .loadb(f1[12]), .loadc(f1[11]), .loads(f1[10]), .write(f1[9]),
        .asel(f1[8]), .bsel(f1[7]), .loadpc(f1[6]), .loadir(f1[5]), .load_addr(f1[4]),
        .msel(f1[3]), .mwrite(f1[2]), .halted(f1[1]), .illegal(f1[0]));

    cpu_controller #(.IW(16), .MEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .nsel(n3), .vsel(v3),
        .loada(f3[13]), .loadb(f3[12]), .loadc(f3[11]), .loads(f3[10]), .write(f3[9]),
        .asel(f3[8]), .bsel(f3[7]), .loadpc(f3[6]), .loadir(f3[5]), .load_addr(f3[4]),
        .msel(f3[3]), .mwrite(f3[2]), .halted(f3[1]), .illegal(f3[0]));

    int total = 0;
    int bad = 0;
    int collide = 0;
    int mw_cnt = 0;

    always @(negedge clk) begin
        if ((f0[9] && f0[2]) || (f1[9] && f1[2]) || (f3[9] && f3[2])) collide++;
        if (f1[2]) mw_cnt++;
    end

    function automatic logic [17:0] cw(input logic [1:0] n, input logic [1:0] v,
                                       input logic [13:0] f);
        return {n, v, f};
    endfunction

    function automatic logic [17:0] obs(input int w);
        case (w)
            0:       return {n0, v0, f0};
            3:       return {n3, v3, f3};
            default: return {n1, v1, f1};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step(input string tag, input int w, input logic [17:0] e);
        @(posedge clk);
        #1;
        chk(tag, obs(w), e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_dut0", obs(0), 18'd0);
        chk("rst_dut1", obs(1), 18'd0);
        chk("rst_dut3", obs(3), 18'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // MOV R1,#5 with one fetch wait cycle
        run = 1'b1;
        instr = 16'hD105;
        do_reset();
        step("movi_pc",   1, cw(0, 0, F_LOADPC));
        step("movi_wait", 1, cw(0, 0, F_NONE));
        step("movi_ir",   1, cw(0, 0, F_LOADIR));
        step("movi_dec",  1, cw(0, 0, F_NONE));
        step("movi_wr",   1, cw(2'b00, 2'b01, F_WRITE));
        step("movi_pc2",  1, cw(0, 0, F_LOADPC));

        // Same instruction with the fetch wait skipped
        do_reset();
        step("w0_pc",  0, cw(0, 0, F_LOADPC));
        step("w0_ir",  0, cw(0, 0, F_LOADIR));
        step("w0_dec", 0, cw(0, 0, F_NONE));
        step("w0_wr",  0, cw(2'b00, 2'b01, F_WRITE));
        step("w0_pc2", 0, cw(0, 0, F_LOADPC));

        // ADD with three fetch wait cycles
        instr = 16'hA0C2;
        do_reset();
        step("add_pc", 3, cw(0, 0, F_LOADPC));
        for (int i = 0; i < 3; i++) step("add_wait", 3, cw(0, 0, F_NONE));
        step("add_ir",   3, cw(0, 0, F_LOADIR));
        step("add_dec",  3, cw(0, 0, F_NONE));
        step("add_geta", 3, cw(2'b00, 0, F_LOADA));
        step("add_getb", 3, cw(2'b10, 0, F_LOADB));
        step("add_exec", 3, cw(0, 0, F_LOADC));
        step("add_wrc",  3, cw(2'b01, 2'b11, F_WRITE));
        step("add_pc2",  3, cw(0, 0, F_LOADPC));

        // CMP: status load, no writeback
        instr = 16'hA900;
        do_reset();
        step("cmp_pc",   1, cw(0, 0, F_LOADPC));
        step("cmp_wait", 1, cw(0, 0, F_NONE));
        step("cmp_ir",   1, cw(0, 0, F_LOADIR));
        step("cmp_dec",  1, cw(0, 0, F_NONE));
        step("cmp_geta", 1, cw(2'b00, 0, F_LOADA));
        step("cmp_getb", 1, cw(2'b10, 0, F_LOADB));
        step("cmp_ex",   1, cw(0, 0, F_LOADS));
        step("cmp_pc2",  1, cw(0, 0, F_LOADPC));

        // LDR with a 3-cycle memory read
        instr = 16'h6123;
        do_reset();
        step("ldr_pc", 3, cw(0, 0, F_LOADPC));
        for (int i = 0; i < 3; i++) step("ldr_fwait", 3, cw(0, 0, F_NONE));
        step("ldr_ir",    3, cw(0, 0, F_LOADIR));
        step("ldr_dec",   3, cw(0, 0, F_NONE));
        step("ldr_geta",  3, cw(2'b00, 0, F_LOADA));
        step("ldr_addr",  3, cw(0, 0, F_BSEL | F_LOADC));
        step("ldr_latch", 3, cw(0, 0, F_LADDR));
        for (int i = 0; i < 3; i++) step("ldr_memrd", 3, cw(0, 0, F_MSEL));
        step("ldr_wrm",   3, cw(2'b01, 2'b00, F_MSEL | F_WRITE));
        step("ldr_pc2",   3, cw(0, 0, F_LOADPC));

        // STR stalled for four cycles in PASS
        instr = 16'h8125;
        do_reset();
        mw_cnt = 0;
        step("str_pc",    1, cw(0, 0, F_LOADPC));
        step("str_wait",  1, cw(0, 0, F_NONE));
        step("str_ir",    1, cw(0, 0, F_LOADIR));
        step("str_dec",   1, cw(0, 0, F_NONE));
        step("str_geta",  1, cw(2'b00, 0, F_LOADA));
        step("str_addr",  1, cw(0, 0, F_BSEL | F_LOADC));
        step("str_latch", 1, cw(0, 0, F_LADDR));
        step("str_getb",  1, cw(2'b01, 0, F_LOADB));
        step("str_pass",  1, cw(0, 0, F_ASEL | F_LOADC));
        run = 1'b0;
        #1;
        chk("str_stall0", obs(1), cw(0, 0, F_ASEL));
        for (int i = 0; i < 4; i++) step("str_stall", 1, cw(0, 0, F_ASEL));
        run = 1'b1;
        #1;
        chk("str_resume", obs(1), cw(0, 0, F_ASEL | F_LOADC));
        step("str_memwr", 1, cw(0, 0, F_MSEL | F_MWRITE));
        step("str_pc2",   1, cw(0, 0, F_LOADPC));
        chk("str_mw_once", 18'(mw_cnt), 18'd1);

        // Undefined opcode, then HALT
        instr = 16'h7800;
        do_reset();
        step("ill_pc",   1, cw(0, 0, F_LOADPC));
        step("ill_wait", 1, cw(0, 0, F_NONE));
        step("ill_ir",   1, cw(0, 0, F_LOADIR));
        step("ill_dec",  1, cw(0, 0, F_ILLEGAL));
        step("ill_pc2",  1, cw(0, 0, F_LOADPC));
        instr = 16'hE000;
        step("hlt_wait", 1, cw(0, 0, F_NONE));
        step("hlt_ir",   1, cw(0, 0, F_LOADIR));
        step("hlt_dec",  1, cw(0, 0, F_NONE));
        step("hlt_enter", 1, cw(0, 0, F_HALTED));
        for (int i = 0; i < 20; i++) begin
            run = (i % 2 == 0);
            step("hlt_hold", 1, cw(0, 0, F_HALTED));
        end
        run = 1'b1;

        // Reset asserted while LDR sits in MEM_RD
        instr = 16'h6123;
        do_reset();
        step("rld_pc",    1, cw(0, 0, F_LOADPC));
        step("rld_wait",  1, cw(0, 0, F_NONE));
        step("rld_ir",    1, cw(0, 0, F_LOADIR));
        step("rld_dec",   1, cw(0, 0, F_NONE));
        step("rld_geta",  1, cw(2'b00, 0, F_LOADA));
        step("rld_addr",  1, cw(0, 0, F_BSEL | F_LOADC));
        step("rld_latch", 1, cw(0, 0, F_LADDR));
        step("rld_memrd", 1, cw(0, 0, F_MSEL));
        #2;
        reset = 1'b1;
        #1;
        chk("rld_rst_now", obs(1), 18'd0);
        step("rld_rst_hold1", 1, 18'd0);
        step("rld_rst_hold2", 1, 18'd0);
        @(negedge clk);
        reset = 1'b0;
        step("rld_refetch", 1, cw(0, 0, F_LOADPC));
        step("rld_rewait",  1, cw(0, 0, F_NONE));
        step("rld_reir",    1, cw(0, 0, F_LOADIR));

        chk("no_collide", 18'(collide), 18'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
